// File: rtl/k16_text_pkg.sv
// Shared constants, attribute layout and colour helpers for the K16 text renderer.
package k16_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  // cram_data layout: {bg[3:0], fg[3:0], code[7:0]}
  localparam int CODE_LSB = 0;
  localparam int FG_LSB   = 8;
  localparam int BG_LSB   = 12;

  typedef enum logic {
    BLINK_HIDDEN = 1'b0,
    BLINK_SHOWN  = 1'b1
  } blink_phase_t;

  // Standard 16-colour CGA palette, 4 bits per channel.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      default: rgb = 12'hFFF;
    endcase
    return rgb;
  endfunction

  // Constant multiplier as a sum of shifted copies of row; no hard multiplier needed.
  function automatic logic [11:0] row_times_cols(input logic [4:0] row, input logic [6:0] cols);
    logic [11:0] acc;
    acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (cols[i]) acc = acc + (12'(row) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/k16_text_renderer_if.sv
// Character RAM / font ROM read bus between the renderer and its memories.
interface k16_text_renderer_if;
  logic [11:0] cram_addr;
  logic [15:0] cram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output cram_addr,
    output font_addr,
    input  cram_data,
    input  font_data
  );

  modport slave (
    input  cram_addr,
    input  font_addr,
    output cram_data,
    output font_data
  );
endinterface

// File: rtl/k16_blink_timer.sv
// Cursor blink timer: counts vsync falling edges and toggles the visible phase.
module k16_blink_timer
  import k16_text_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         v_sync_in,
  output blink_phase_t phase
);

  logic       v_sync_q;
  logic [5:0] frame_cnt;
  logic       v_fall;

  assign v_fall = v_sync_q & ~v_sync_in;

  // Edge register resets to the idle (high) sync level so a release with vsync
  // already high never fakes a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_sync_q  <= 1'b1;
      frame_cnt <= '0;
      phase     <= BLINK_SHOWN;
    end else begin
      v_sync_q <= v_sync_in;
      if (v_fall) begin
        if (frame_cnt == 6'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= (phase == BLINK_SHOWN) ? BLINK_HIDDEN : BLINK_SHOWN;
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/k16_text_renderer.sv
// 80x30 text-mode pixel generator: three-stage char/font fetch pipeline with cursor overlay.
module k16_text_renderer
  import k16_text_pkg::*;
#(
  parameter int COLS         = k16_text_pkg::COLS,
  parameter int ROWS         = k16_text_pkg::ROWS,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 hpos,
  input  logic [9:0]                 vpos,
  input  logic                       display_on,
  input  logic                       h_sync_in,
  input  logic                       v_sync_in,
  k16_text_renderer_if.master        mem,
  input  logic [6:0]                 cursor_col,
  input  logic [4:0]                 cursor_row,
  input  logic                       cursor_en,
  output logic [11:0]                vga_rgb,
  output logic                       vga_h_sync,
  output logic                       vga_v_sync
);

  if (COLS * CHAR_W > 1024 || ROWS * CHAR_H > 512 || BLINK_FRAMES < 1 || BLINK_FRAMES > 63)
  begin : g_bad_params
    $error("k16_text_renderer: parameter out of range");
  end

  blink_phase_t blink_phase;

  k16_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .v_sync_in (v_sync_in),
    .phase     (blink_phase)
  );

  logic [6:0] col;
  logic [4:0] row;
  logic [2:0] px;
  logic [3:0] grow;
  logic       unused_vpos_msb;
  logic       hit_s0;

  assign col             = hpos[9:3];
  assign row             = vpos[8:4];
  assign px              = hpos[2:0];
  assign grow            = vpos[3:0];
  assign unused_vpos_msb = vpos[9];

  assign hit_s0 = cursor_en && (col == cursor_col) && (row == cursor_row) &&
                  (grow >= 4'(CHAR_H - 2)) && (blink_phase == BLINK_SHOWN);

  // Stage 0: issue the character RAM read.
  logic [2:0] px_s0;
  logic [3:0] grow_s0;
  logic       de_s0, hs_s0, vs_s0, hit_q0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.cram_addr <= '0;
      px_s0         <= '0;
      grow_s0       <= '0;
      de_s0         <= 1'b0;
      hs_s0         <= 1'b1;
      vs_s0         <= 1'b1;
      hit_q0        <= 1'b0;
    end else begin
      mem.cram_addr <= row_times_cols(row, 7'(COLS)) + 12'(col);
      px_s0         <= px;
      grow_s0       <= grow;
      de_s0         <= display_on;
      hs_s0         <= h_sync_in;
      vs_s0         <= v_sync_in;
      hit_q0        <= hit_s0;
    end
  end

  // Stage 1: character data is back; issue the font ROM read.
  logic [7:0] attr_s1;
  logic [2:0] px_s1;
  logic       de_s1, hs_s1, vs_s1, hit_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.font_addr <= '0;
      attr_s1       <= '0;
      px_s1         <= '0;
      de_s1         <= 1'b0;
      hs_s1         <= 1'b1;
      vs_s1         <= 1'b1;
      hit_s1        <= 1'b0;
    end else begin
      mem.font_addr <= {mem.cram_data[CODE_LSB +: 8], grow_s0};
      attr_s1       <= mem.cram_data[FG_LSB +: 8];
      px_s1         <= px_s0;
      de_s1         <= de_s0;
      hs_s1         <= hs_s0;
      vs_s1         <= vs_s0;
      hit_s1        <= hit_q0;
    end
  end

  // Stage 2: glyph bit select, cursor inversion and palette lookup.
  logic        pix;
  logic [11:0] colour;

  always_comb begin
    pix    = mem.font_data[3'd7 - px_s1] ^ hit_s1;
    colour = pix ? palette(attr_s1[FG_LSB - 8 +: 4]) : palette(attr_s1[BG_LSB - 8 +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_rgb    <= '0;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else begin
      vga_rgb    <= de_s1 ? colour : 12'h000;
      vga_h_sync <= hs_s1;
      vga_v_sync <= vs_s1;
    end
  end

endmodule

// File: tb/tb_k16_text_renderer.sv
// Scoreboard bench for k16_text_renderer: directed pixels, syncs, cursor and blink.
module tb_k16_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on, h_sync_in, v_sync_in;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic [11:0] vga_rgb;
  logic        vga_h_sync, vga_v_sync;

  k16_text_renderer_if mem_if ();

  k16_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .mem        (mem_if.master),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_en  (cursor_en),
    .vga_rgb    (vga_rgb),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync)
  );

  always #5 clk = ~clk;

  // Memory contents: only a few locations hold non-zero data.
  function automatic logic [15:0] cram_model(input logic [11:0] a);
    case (a)
      12'd162: return 16'h1F41;
      12'd321: return 16'h4E42;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] font_model(input logic [11:0] a);
    case (a)
      12'h413: return 8'h80;
      12'h41F: return 8'h40;
      12'h420: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  assign mem_if.cram_data = cram_model(mem_if.cram_addr);
  assign mem_if.font_data = font_model(mem_if.font_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops each expectation on the cycle its output is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("vga_rgb", 32'(vga_rgb), 32'(e.rgb));
        check("vga_h_sync", 32'(vga_h_sync), 32'(e.hs));
        check("vga_v_sync", 32'(vga_v_sync), 32'(e.vs));
      end
    end
  end

  // One call = one pixel clock of stimulus, entered and left at a falling edge.
  task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs,
                       input logic [11:0] rgb, input bit push);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = de;
    h_sync_in  = hs;
    v_sync_in  = vs;
    if (push) q.push_back('{rgb: rgb, hs: hs, vs: vs, due: cyc + 3});
    @(negedge clk);
  endtask

  task automatic vsync_fall();
    drive(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    reset      = 1'b1;
    hpos       = '0;
    vpos       = '0;
    display_on = 1'b0;
    h_sync_in  = 1'b1;
    v_sync_in  = 1'b1;
    cursor_col = '0;
    cursor_row = '0;
    cursor_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(vga_rgb), 32'h000);
    check("reset_hs", 32'(vga_h_sync), 32'd1);
    check("reset_vs", 32'(vga_v_sync), 32'd1);
    check("reset_cram_addr", 32'(mem_if.cram_addr), 32'd0);
    check("reset_font_addr", 32'(mem_if.font_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Address path, including the last cell of the screen.
    drive(17, 35, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    check("cram_addr_c2r2", 32'(mem_if.cram_addr), 32'd162);
    drive(8, 64, 1'b1, 1'b1, 1'b1, 12'hFF5, 1'b1);
    check("font_addr_41", 32'(mem_if.font_addr), 32'h413);
    check("cram_addr_c1r4", 32'(mem_if.cram_addr), 32'd321);
    drive(632, 464, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    check("font_addr_42", 32'(mem_if.font_addr), 32'h420);
    check("cram_addr_c79r29", 32'(mem_if.cram_addr), 32'd2399);
    drive(9, 64, 1'b1, 1'b1, 1'b1, 12'hA00, 1'b1);
    check("font_addr_00", 32'(mem_if.font_addr), 32'h000);
    check("cram_addr_c1r4b", 32'(mem_if.cram_addr), 32'd321);

    // Pixel colours and blanking.
    drive(16, 35, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    drive(17, 35, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drive(23, 35, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drive(10, 64, 1'b1, 1'b1, 1'b1, 12'hFF5, 1'b1);
    drive(16, 35, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1);
    drain();

    // A line with a 96-clock hsync pulse; visible for the first 100 clocks.
    for (int i = 0; i < 200; i++) begin
      logic [11:0] e;
      if (i >= 100)                e = 12'h000;
      else if (i == 16)            e = 12'hFFF;
      else if (i >= 17 && i <= 23) e = 12'h00A;
      else                         e = 12'h000;
      drive(i, 35, (i < 100), !(i >= 40 && i < 136), 1'b1, e, 1'b1);
    end
    drain();

    // Cursor overlay at (2,2) on the last two glyph rows only.
    cursor_col = 7'd2;
    cursor_row = 5'd2;
    cursor_en  = 1'b1;
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    drive(16, 45, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drive(16, 47, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    drive(17, 47, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drive(24, 46, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    cursor_en = 1'b0;
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    cursor_en = 1'b1;
    drain();

    // Blink with a half-period of two frames.
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    vsync_fall();
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    vsync_fall();
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    vsync_fall();
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    vsync_fall();
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    vsync_fall();
    vsync_fall();
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drain();

    // Asynchronous reset mid-line, cursor phase hidden beforehand.
    repeat (4) drive(16, 35, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0);
    check("pre_reset_rgb", 32'(vga_rgb), 32'hFFF);
    check("pre_reset_hs", 32'(vga_h_sync), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_rgb", 32'(vga_rgb), 32'h000);
    check("async_reset_hs", 32'(vga_h_sync), 32'd1);
    check("async_reset_vs", 32'(vga_v_sync), 32'd1);
    check("async_reset_cram_addr", 32'(mem_if.cram_addr), 32'd0);
    check("async_reset_font_addr", 32'(mem_if.font_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(16, 46, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    drive(17, 35, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
